// File: rtl/switch_led_ctrl_pkg.sv
// switch_led_ctrl_pkg: display mode encodings and counter sizing shared by the switch/LED path
package switch_led_ctrl_pkg;
  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_INVERT = 2'd3
  } mode_e;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/switch_debounce.sv
// switch_debounce: one channel of two-flop synchroniser, debounce counter and rising-edge pulse
module switch_debounce
  import switch_led_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic switch_i,
  output logic sw_clean_o,
  output logic sw_rise_o
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  logic s1_q, s2_q, clean_q, prev_q, rise_q, clean_d, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable, done;
  always_comb begin
    stable  = s2_q == clean_q;
    done    = cnt_q == CMAX;
    cnt_d   = (stable || done) ? '0 : cnt_q + 1'b1;
    clean_d = clean_q ^ (!stable && done);
    rise_d  = clean_q & ~prev_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      s1_q    <= switch_i;
      s2_q    <= s1_q;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      prev_q  <= clean_q;
      rise_q  <= rise_d;
    end
  end
  assign sw_clean_o = clean_q;
  assign sw_rise_o  = rise_q;
endmodule

// File: rtl/switch_led_ctrl.sv
// switch_led_ctrl: per-channel conditioned switches driving registered LEDs in four display modes
module switch_led_ctrl
  import switch_led_ctrl_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 270000,
  parameter int BLINK_CYCLES    = 6750000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] switch,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] led
);
  localparam int BW = cnt_w(BLINK_CYCLES);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_CYCLES - 1);
  logic [WIDTH-1:0] tog_q, tog_d, led_q, led_d;
  logic [BW-1:0] blink_q, blink_d;
  logic phase_q, phase_d, wrap;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    switch_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk       (clk),
      .reset_n   (reset_n),
      .switch_i  (switch[i]),
      .sw_clean_o(sw_clean[i]),
      .sw_rise_o (sw_rise[i])
    );
  end
  // blink timebase and toggle state run in every mode so mode switches show live state
  always_comb begin
    wrap    = blink_q == BMAX;
    blink_d = wrap ? '0 : blink_q + 1'b1;
    phase_d = phase_q ^ wrap;
    tog_d   = tog_q ^ sw_rise;
    led_d   = (mode == MODE_PASS)   ? sw_clean :
              (mode == MODE_TOGGLE) ? tog_q :
              (mode == MODE_BLINK)  ? (sw_clean & {WIDTH{phase_q}}) : ~sw_clean;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tog_q   <= '0;
      led_q   <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      tog_q   <= tog_d;
      led_q   <= led_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end
  assign led = led_q;
endmodule

// File: tb/tb_switch_led_ctrl.sv
// tb_switch_led_ctrl: randomized and directed stimulus checked against a history-based reference model
module tb_switch_led_ctrl;
  localparam int W = 8, D = 4, B = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [W-1:0] switch = '0;
  logic [1:0] mode = 2'd0;
  logic [W-1:0] sw_clean, sw_rise, led;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] m_p1, m_p2, m_clean, m_prev, m_rise, m_tog, m_led;
  logic [W-1:0] m_hist [D];
  int m_n;

  always #5 clk = ~clk;

  switch_led_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
    .clk(clk), .reset_n(reset_n), .switch(switch), .mode(mode),
    .sw_clean(sw_clean), .sw_rise(sw_rise), .led(led)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // a level is accepted once the synchronised input has shown it for D consecutive edges;
  // blink phase is simply elapsed cycles since reset divided by B
  task automatic model_edge();
    logic [W-1:0] a, o, s2e, nclean;
    bit ph;
    if (!reset_n) begin
      m_p1 = '0; m_p2 = '0; m_clean = '0; m_prev = '0; m_rise = '0;
      m_tog = '0; m_led = '0; m_n = 0;
      foreach (m_hist[k]) m_hist[k] = '0;
      return;
    end
    s2e = m_p2; m_p2 = m_p1; m_p1 = switch;
    for (int k = D - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
    m_hist[0] = s2e;
    a = '1; o = '0;
    foreach (m_hist[k]) begin a &= m_hist[k]; o |= m_hist[k]; end
    nclean = a | (m_clean & o);
    ph = ((m_n / B) % 2) == 1;
    case (mode)
      2'd0: m_led = m_clean;
      2'd1: m_led = m_tog;
      2'd2: m_led = ph ? m_clean : '0;
      default: m_led = ~m_clean;
    endcase
    m_tog = m_tog ^ m_rise;
    m_rise = m_clean & ~m_prev;
    m_prev = m_clean;
    m_clean = nclean;
    m_n++;
  endtask

  task automatic tick(input int n = 1);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("clean", sw_clean, m_clean);
      chk("rise", sw_rise, m_rise);
      chk("led", led, m_led);
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    tick(n);
    reset_n = 1'b1;
  endtask

  initial begin
    int hold;
    reset_n = 1'b0; switch = 8'hFF; mode = 2'd0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("rst_clean", sw_clean, 8'h00);
      chk("rst_rise", sw_rise, 8'h00);
      chk("rst_led", led, 8'h00);
    end
    reset_n = 1'b1; switch = 8'h00;
    tick(10);
    switch = 8'h01;
    tick(5);
    chk("step_pre", sw_clean, 8'h00);
    tick();
    chk("step_clean", sw_clean, 8'h01);
    chk("step_led_lag", led, 8'h00);
    tick();
    chk("step_rise", sw_rise, 8'h01);
    chk("step_led", led, 8'h01);
    tick();
    chk("step_rise_end", sw_rise, 8'h00);
    tick(4);
    switch = 8'h00;
    tick(12);
    switch = 8'h08;
    tick(3);
    switch = 8'h00;
    tick(12);
    chk("glitch_clean", sw_clean, 8'h00);
    chk("glitch_led", led, 8'h00);
    do_reset(2);
    mode = 2'd1;
    switch = 8'h04; tick(10); switch = 8'h00; tick(10);
    chk("tog_first", led, 8'h04);
    switch = 8'h04; tick(10); switch = 8'h00; tick(10);
    chk("tog_second", led, 8'h00);
    mode = 2'd2; switch = 8'hA5;
    tick(40);
    mode = 2'd3;
    tick();
    chk("invert", led, 8'h5A);
    // mid-debounce and mid-blink reset, then switch held high through release
    switch = 8'hFF; tick(3);
    do_reset(1);
    mode = 2'd2;
    tick(20);
    for (int v = 0; v < 256; v++) begin
      switch = 8'(v);
      mode = 2'($urandom_range(0, 3));
      tick(10);
    end
    for (int j = 0; j < 600; j++) begin
      if ($urandom_range(0, 199) == 0) do_reset($urandom_range(1, 3));
      switch = 8'($urandom);
      if ($urandom_range(0, 3) == 0) mode = 2'($urandom_range(0, 3));
      hold = $urandom_range(1, 8);
      tick(hold);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
